// File: rtl/vita49_pkt_framer_if.sv
// AXI4-Stream bundle shared by the framer's sample input and packet output.
//   TDATA  : 8*NUM_BYTES-bit stream word
//   TSTRB  : byte strobes
//   TLAST  : end of packet
//   TVALID : source has a word
//   TREADY : sink accepts the word
// master drives TDATA/TSTRB/TLAST/TVALID; slave drives TREADY.
interface vita49_pkt_framer_if #(
   parameter int unsigned NUM_BYTES = 4
);
   logic [8*NUM_BYTES-1:0] TDATA;
   logic [NUM_BYTES-1:0]   TSTRB;
   logic                   TLAST;
   logic                   TVALID;
   logic                   TREADY;

   modport master (output TDATA, TSTRB, TLAST, TVALID, input TREADY);
   modport slave  (input TDATA, TSTRB, TLAST, TVALID, output TREADY);
endinterface

// File: rtl/vita49_pkt_framer.sv
// VITA-49 IF Data packet framer: wraps a continuous 32-bit sample stream
// into packets of header, Stream ID, TSI, TSF (two words) and N payload
// words. Timestamps and Stream ID are captured when a packet starts.
// Ports:
//   AXIS_ACLK, AXIS_ARESET : clock, synchronous active-high reset
//   S_AXIS (slave)         : sample input; TSTRB/TLAST ignored
//   M_AXIS (master)        : framed packet output, TSTRB tied to 4'hF
//   en                     : framing enable, sampled only between packets
//   stream_id, tsi, tsf    : header field sources
//   payload_words          : payload length N (0 behaves as 1)
//   pkt_sent               : saturating count of completed packets
//   busy                   : high while a packet is in progress
// Build option: define VITA49_FRAMER_TRAILER_EN to append an all-zero
// trailer word and set the header T bit.
module vita49_pkt_framer #(
   parameter int unsigned C_AXIS_TDATA_NUM_BYTES = 4,
   parameter int unsigned C_LEN_W                = 16
) (
   input  logic                 AXIS_ACLK,
   input  logic                 AXIS_ARESET,
   vita49_pkt_framer_if.slave   S_AXIS,
   vita49_pkt_framer_if.master  M_AXIS,
   input  logic                 en,
   input  logic [31:0]          stream_id,
   input  logic [C_LEN_W-1:0]   payload_words,
   input  logic [31:0]          tsi,
   input  logic [63:0]          tsf,
   output logic [31:0]          pkt_sent,
   output logic                 busy
);

   if (C_AXIS_TDATA_NUM_BYTES != 4) begin : g_width_check
      $error("vita49_pkt_framer: C_AXIS_TDATA_NUM_BYTES must be 4");
   end

`ifdef VITA49_FRAMER_TRAILER_EN
   localparam logic        T_BIT    = 1'b1;
   localparam int unsigned OVERHEAD = 6;
`else
   localparam logic        T_BIT    = 1'b0;
   localparam int unsigned OVERHEAD = 5;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_SID,
      S_TSI,
      S_TSFH,
      S_TSFL,
      S_PAYLOAD
`ifdef VITA49_FRAMER_TRAILER_EN
      , S_TRAILER
`endif
   } state_t;

   state_t               state_q;
   logic [31:0]          data_q;
   logic                 valid_q;
   logic                 last_q;
   logic [31:0]          sid_q;
   logic [31:0]          tsi_q;
   logic [63:0]          tsf_q;
   logic [C_LEN_W-1:0]   n_q;
   logic [C_LEN_W-1:0]   cnt_q;
   logic [3:0]           pkt_cnt_q;

   logic [C_LEN_W-1:0]   n_eff_c;
   logic [15:0]          size_c;
   logic [31:0]          hdr_word_c;
   logic                 in_payload_c;
   logic                 last_word_c;
   logic                 pay_last_c;
   logic                 unused_in_c;

   assign unused_in_c = ^{S_AXIS.TSTRB, S_AXIS.TLAST};

   // Header word for the packet about to start
   assign n_eff_c    = (payload_words == '0) ? C_LEN_W'(1) : payload_words;
   assign size_c     = 16'(n_eff_c) + 16'(OVERHEAD);
   assign hdr_word_c = {4'b0001, 1'b0, T_BIT, 2'b00, 2'b01, 2'b10, pkt_cnt_q, size_c};

   assign in_payload_c = (state_q == S_PAYLOAD);
   assign last_word_c  = (cnt_q == n_q - C_LEN_W'(1));

`ifdef VITA49_FRAMER_TRAILER_EN
   assign pay_last_c = 1'b0;
`else
   assign pay_last_c = last_word_c;
`endif

   // Payload is a zero-latency passthrough; all other words come from data_q
   assign M_AXIS.TDATA  = in_payload_c ? S_AXIS.TDATA  : data_q;
   assign M_AXIS.TVALID = in_payload_c ? S_AXIS.TVALID : valid_q;
   assign M_AXIS.TLAST  = in_payload_c ? pay_last_c    : last_q;
   assign M_AXIS.TSTRB  = 4'hF;
   assign S_AXIS.TREADY = in_payload_c & M_AXIS.TREADY;

   // Framing state machine with registered header words and status
   always_ff @(posedge AXIS_ACLK) begin
      if (AXIS_ARESET) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         sid_q     <= '0;
         tsi_q     <= '0;
         tsf_q     <= '0;
         n_q       <= C_LEN_W'(1);
         cnt_q     <= '0;
         pkt_cnt_q <= '0;
         pkt_sent  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en && S_AXIS.TVALID) begin
                  sid_q   <= stream_id;
                  tsi_q   <= tsi;
                  tsf_q   <= tsf;
                  n_q     <= n_eff_c;
                  cnt_q   <= '0;
                  data_q  <= hdr_word_c;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  busy    <= 1'b1;
                  state_q <= S_HDR;
               end
            end
            S_HDR: if (M_AXIS.TREADY) begin
               data_q  <= sid_q;
               state_q <= S_SID;
            end
            S_SID: if (M_AXIS.TREADY) begin
               data_q  <= tsi_q;
               state_q <= S_TSI;
            end
            S_TSI: if (M_AXIS.TREADY) begin
               data_q  <= tsf_q[63:32];
               state_q <= S_TSFH;
            end
            S_TSFH: if (M_AXIS.TREADY) begin
               data_q  <= tsf_q[31:0];
               state_q <= S_TSFL;
            end
            S_TSFL: if (M_AXIS.TREADY) begin
               data_q  <= '0;
               valid_q <= 1'b0;
               state_q <= S_PAYLOAD;
            end
            S_PAYLOAD: begin
               if (S_AXIS.TVALID && M_AXIS.TREADY) begin
                  cnt_q <= cnt_q + C_LEN_W'(1);
                  if (last_word_c) begin
`ifdef VITA49_FRAMER_TRAILER_EN
                     data_q  <= '0;
                     valid_q <= 1'b1;
                     last_q  <= 1'b1;
                     state_q <= S_TRAILER;
`else
                     busy      <= 1'b0;
                     pkt_cnt_q <= pkt_cnt_q + 4'd1;
                     if (pkt_sent != 32'hFFFF_FFFF) pkt_sent <= pkt_sent + 32'd1;
                     state_q   <= S_IDLE;
`endif
                  end
               end
            end
`ifdef VITA49_FRAMER_TRAILER_EN
            S_TRAILER: if (M_AXIS.TREADY) begin
               valid_q   <= 1'b0;
               last_q    <= 1'b0;
               busy      <= 1'b0;
               pkt_cnt_q <= pkt_cnt_q + 4'd1;
               if (pkt_sent != 32'hFFFF_FFFF) pkt_sent <= pkt_sent + 32'd1;
               state_q   <= S_IDLE;
            end
`endif
            default: begin
               valid_q <= 1'b0;
               last_q  <= 1'b0;
               busy    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
